ula_arb: RTL and testbench
==========================

ULA_ARB -- requirements
Module: ula_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter WIDTH, default 8: operand and result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  bit i: requester i presents an operation.
REQ-006 req_ready  output  NREQ  bit i: requester i's operation accepted this cycle; one-hot or zero.
REQ-007 req_a  input  NREQ*WIDTH  operand A per requester; slice i = [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NREQ*WIDTH  operand B per requester, same slicing.
REQ-009 req_op  input  NREQ*2  opcode per requester: 00 add, 01 sub, 10 AND, 11 OR.
REQ-010 rsp_valid  output  1  registered result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  $clog2(NREQ)  index of requester owning rsp_result.
REQ-013 rsp_result  output  WIDTH  registered ULA result.
REQ-014 ops_done  output  16  count of completed response handshakes.

Function
REQ-015 Shall share one ula datapath instance among NREQ requesters under round-robin arbitration.
REQ-016 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-017 IDLE: if any req_valid, assert req_ready for winner g in the same cycle, register its a/b/op/id, go EXEC; else stay IDLE.
REQ-018 EXEC: ula computes combinationally from registered operands; register Result into rsp_result; go RESP (exactly one cycle).
REQ-019 RESP: rsp_valid=1; rsp_result and rsp_id held stable until rsp_ready=1.
REQ-020 RESP with rsp_ready=1: increment ops_done; if any req_valid, grant next winner in the same cycle and go EXEC; else go IDLE.
REQ-021 Latency: accept in cycle N -> rsp_valid first high in cycle N+2; peak throughput one op per 2 cycles.
REQ-022 req_ready shall be all-zero in EXEC, and in RESP while rsp_ready=0.
REQ-023 Round-robin: pointer ptr; winner = first i with req_valid[i] searching from ptr upward, wrapping at NREQ-1 -> 0; after grant g, ptr = (g+1) mod NREQ.
REQ-024 Requester that drops req_valid before grant is skipped without penalty.
REQ-025 Arithmetic modulo 2^WIDTH; add carry and sub borrow discarded (5-10 = 251 at WIDTH=8).
REQ-026 ops_done wraps 0xFFFF -> 0x0000.
REQ-027 Operands are sampled only at grant; input changes afterwards do not affect the in-flight result.

Reset
REQ-028 rst=1: next cycle state IDLE, rsp_valid=0, req_ready=0, rsp_result=0, rsp_id=0, ptr=0, ops_done=0.
REQ-029 rst in EXEC or RESP discards the in-flight operation; no response is produced for it.
REQ-030 req_ready shall be 0 in any cycle rst=1.

Structure
REQ-031 Package ula_pkg holds the opcode enum (OP_ADD, OP_SUB, OP_AND, OP_OR), the FSM state enum, and the NREQ/WIDTH defaults.
REQ-032 The existing ula module is instantiated unchanged as the datapath.
REQ-033 Round-robin winner selection shall be one sub-module, rr_arbiter (req vector and ptr in, one-hot grant and index out, purely combinational).

Verification
REQ-034 Req 0 only, a=10, b=5, op=00, accepted cycle N, rsp_ready=1 -> rsp_valid in N+2, rsp_result=15, rsp_id=0, ops_done=1.
REQ-035 Req 1, a=5, b=10, op=01 -> rsp_result=251, rsp_id=1.
REQ-036 Req 2, 0xCC/0xAA op=10 and req 3, 0xCC/0xAA op=11, both valid at once -> responses 0x88 (id 2) then 0xEE (id 3).
REQ-037 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0, one response every 2 cycles.
REQ-038 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_result, rsp_id stable, req_ready=0 throughout, ops_done unchanged.
REQ-039 rst pulsed during EXEC -> next cycle rsp_valid=0, ops_done=0; subsequent grant with all requesters valid goes to id 0.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared types and defaults for the arbitrated ULA block.
//   ula_op_e  - 2-bit opcode (add, sub, and, or)
//   state_e   - control FSM states of ula_arb
//   NREQ_DEF  - default requester count
//   WIDTH_DEF - default operand/result width
package ula_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } ula_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin winner selection.
// Ports:
//   i_req   - request vector (NREQ bits)
//   i_ptr   - highest-priority index; search runs upward from here and wraps
//   o_grant - one-hot grant (zero when no request)
//   o_idx   - index of the granted requester (zero when no request)
//   o_any   - at least one request present
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end
      w_j = w_sum[IW-1:0];
      // First hit in search order wins; later hits are ignored.
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/ula.sv
// ula: combinational arithmetic/logic unit.
// Ports:
//   i_a, i_b  - operands (WIDTH bits, unsigned)
//   i_op      - operation select (ula_op_e)
//   o_result  - result, modulo 2^WIDTH (carry/borrow dropped)
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  ula_op_e          i_op,
  output logic [WIDTH-1:0] o_result
);

  always_comb begin
    o_result = '0;
    unique case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/ula_arb.sv
// ula_arb: one shared ula datapath serving NREQ requesters under round-robin
// arbitration. Accept in cycle N, result presented (rsp_valid) in N+2 and
// held until rsp_ready; a new grant may overlap the response handshake.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   req_valid   - per-requester operation present
//   req_ready   - one-hot accept strobe (same cycle as grant)
//   req_a/req_b - packed operands, slice i = [i*WIDTH +: WIDTH]
//   req_op      - packed 2-bit opcodes, slice i = [i*2 +: 2]
//   rsp_valid   - registered result available
//   rsp_ready   - consumer accepts result
//   rsp_id      - requester owning rsp_result
//   rsp_result  - registered ula result
//   ops_done    - wrapping count of completed response handshakes
module ula_arb
  import ula_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*2-1:0]       req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_result,
  output logic [15:0]             ops_done
);

  localparam int IW = $clog2(NREQ);

  // Per-requester views of the flat operand buses.
  logic [NREQ-1:0][WIDTH-1:0] w_a_arr;
  logic [NREQ-1:0][WIDTH-1:0] w_b_arr;
  logic [NREQ-1:0][1:0]       w_op_arr;

  assign w_a_arr  = req_a;
  assign w_b_arr  = req_b;
  assign w_op_arr = req_op;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     w_ptr_nxt;
  logic [NREQ-1:0]   w_grant;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic              w_grant_en;
  logic              w_rsp_hs;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  ula_op_e           r_op;
  logic [IW-1:0]     r_id;
  logic [WIDTH-1:0]  w_result;

  logic [WIDTH-1:0]  r_rsp_result;
  logic [IW-1:0]     r_rsp_id;
  logic [15:0]       r_ops_done;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  ula #(
    .WIDTH (WIDTH)
  ) u_ula (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = w_any ? EXEC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic. A grant is only possible when the datapath is free: in
  // IDLE, or in RESP on the very cycle the current result is taken.
  always_comb begin
    rsp_valid  = (r_state == RESP);
    w_rsp_hs   = (r_state == RESP) && rsp_ready;
    w_grant_en = !rst && w_any && ((r_state == IDLE) || w_rsp_hs);
    req_ready  = w_grant_en ? w_grant : '0;
  end

  assign w_ptr_nxt = (w_idx == IW'(NREQ-1)) ? '0 : w_idx + 1'b1;

  // Grant: capture operands so later input changes cannot disturb the
  // in-flight operation.
  always_ff @(posedge clk) begin
    if (w_grant_en) begin
      r_a  <= w_a_arr[w_idx];
      r_b  <= w_b_arr[w_idx];
      r_op <= ula_op_e'(w_op_arr[w_idx]);
      r_id <= w_idx;
    end
  end

  // EXEC -> RESP: register result/id; held while RESP waits for rsp_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
      r_ptr        <= '0;
      r_ops_done   <= '0;
    end else begin
      if (r_state == EXEC) begin
        r_rsp_result <= w_result;
        r_rsp_id     <= r_id;
      end
      if (w_grant_en) begin
        r_ptr <= w_ptr_nxt;
      end
      if (w_rsp_hs) begin
        r_ops_done <= r_ops_done + 16'd1;
      end
    end
  end

  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
  assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_ula_arb.sv
// tb_ula_arb: directed bench for ula_arb (NREQ=4, WIDTH=8).
module tb_ula_arb;

  logic            clk;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [3:0][7:0] req_a;
  logic [3:0][7:0] req_b;
  logic [3:0][1:0] req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_result;
  logic [15:0]     ops_done;

  int checks   = 0;
  int failures = 0;

  ula_arb #(
    .NREQ  (4),
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    #2;
    chk("ready_low_in_reset", {28'd0, req_ready}, 32'h0);
    tick();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_ops_done", {16'd0, ops_done}, 32'd0);
    rst       = 1'b0;
    req_valid = 4'h0;
    tick();

    // Req 0: 10 + 5, latency N -> N+2
    req_a[0]  = 8'd10; req_b[0] = 8'd5; req_op[0] = 2'b00;
    req_valid = 4'b0001;
    #1 chk("t1_grant", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = 4'b0000;
    req_a[0]  = 8'hFF;
    #1 chk("t1_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t1_exec_ready", {28'd0, req_ready}, 32'h0);
    tick();
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_result", {24'd0, rsp_result}, 32'd15);
    chk("t1_id", {30'd0, rsp_id}, 32'd0);
    tick();
    chk("t1_ops_done", {16'd0, ops_done}, 32'd1);
    chk("t1_idle_valid", {31'd0, rsp_valid}, 32'd0);

    // Req 1: 5 - 10 wraps to 251
    req_a[1]  = 8'd5; req_b[1] = 8'd10; req_op[1] = 2'b01;
    req_valid = 4'b0010;
    #1 chk("t2_grant", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t2_result", {24'd0, rsp_result}, 32'd251);
    chk("t2_id", {30'd0, rsp_id}, 32'd1);
    tick();
    chk("t2_ops_done", {16'd0, ops_done}, 32'd2);

    // Req 2 AND and req 3 OR, both valid together
    req_a[2] = 8'hCC; req_b[2] = 8'hAA; req_op[2] = 2'b10;
    req_a[3] = 8'hCC; req_b[3] = 8'hAA; req_op[3] = 2'b11;
    req_valid = 4'b1100;
    #1 chk("t3_grant2", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid = 4'b1000;
    #1 chk("t3_exec_ready", {28'd0, req_ready}, 32'h0);
    tick();
    chk("t3_result2", {24'd0, rsp_result}, 32'h88);
    chk("t3_id2", {30'd0, rsp_id}, 32'd2);
    chk("t3_grant3_overlap", {28'd0, req_ready}, 32'h8);
    tick();
    req_valid = 4'b0000;
    chk("t3_ops_done_a", {16'd0, ops_done}, 32'd3);
    tick();
    chk("t3_result3", {24'd0, rsp_result}, 32'hEE);
    chk("t3_id3", {30'd0, rsp_id}, 32'd3);
    tick();
    chk("t3_ops_done_b", {16'd0, ops_done}, 32'd4);

    // All four valid: grant order 0,1,2,3,0, one response per 2 cycles
    req_a  = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b  = {4{8'h10}};
    req_op = '0;
    req_valid = 4'hF;
    #1 chk("t4_first_grant", {28'd0, req_ready}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_exec_valid", {31'd0, rsp_valid}, 32'd0);
      chk("t4_exec_ready", {28'd0, req_ready}, 32'h0);
      if (k == 4) req_valid = 4'h0;
      tick();
      #1;
      chk("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t4_rsp_id", {30'd0, rsp_id}, 32'(k % 4));
      chk("t4_rsp_result", {24'd0, rsp_result}, 32'(8'h11 + (k % 4)));
      if (k < 4) chk("t4_next_grant", {28'd0, req_ready}, 32'(1 << ((k + 1) % 4)));
    end
    tick();
    chk("t4_ops_done", {16'd0, ops_done}, 32'd9);
    chk("t4_back_idle", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: ptr now 1; hold RESP for 5 cycles
    req_a[1] = 8'h20; req_b[1] = 8'h03; req_op[1] = 2'b01;
    req_valid = 4'b0010;
    #1 chk("t5_grant", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b0001;
    req_a[0]  = 8'h07; req_b[0] = 8'h09; req_op[0] = 2'b00;
    rsp_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      req_a[1] = 8'(k);
      #1;
      chk("t5_stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t5_stall_result", {24'd0, rsp_result}, 32'h1D);
      chk("t5_stall_id", {30'd0, rsp_id}, 32'd1);
      chk("t5_stall_ready", {28'd0, req_ready}, 32'h0);
      chk("t5_stall_ops", {16'd0, ops_done}, 32'd9);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("t5_release_grant", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = 4'h0;
    chk("t5_ops_done", {16'd0, ops_done}, 32'd10);

    // Reset during EXEC discards the in-flight op
    rst       = 1'b1;
    req_valid = 4'hF;
    #1 chk("t6_ready_in_rst", {28'd0, req_ready}, 32'h0);
    tick();
    rst = 1'b0;
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_ops_done", {16'd0, ops_done}, 32'd0);
    #1 chk("t6_grant_id0", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = 4'h0;
    chk("t6_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("t6_result", {24'd0, rsp_result}, 32'h10);
    chk("t6_id", {30'd0, rsp_id}, 32'd0);
    tick();
    chk("t6_ops_after", {16'd0, ops_done}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
